// File: rtl/seq_add_arbiter_if.sv
// Requester/response bundle for seq_add_arbiter.
// master = requesters + result consumer; slave = the arbiter.
interface seq_add_arbiter_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8
);
   localparam int unsigned IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [W-1:0]      rsp_data;
   logic [IDW-1:0]    rsp_id;
   logic              busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_id, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_id, busy
   );
endinterface

// File: rtl/seq_add_arbiter.sv
// Round-robin arbiter sharing one registered W-bit adder among NREQ requesters.
// Optional macro SEQ_ADD_ARBITER_SATURATE_EN: saturate the sum instead of wrapping.
module seq_add_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = 8
) (
   input logic              clk,
   input logic              rst,
   seq_add_arbiter_if.slave bus
);
   localparam int unsigned IDW = $clog2(NREQ);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t         state, state_nxt;
   logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
   logic           rsp_valid_q, rsp_valid_nxt;
   logic [W-1:0]   rsp_data_q, rsp_data_nxt;
   logic [IDW-1:0] rsp_id_q, rsp_id_nxt;

   logic [W-1:0]   a_arr [NREQ];
   logic [W-1:0]   b_arr [NREQ];
   logic           found;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] idx;
   int unsigned    scan;
   logic [W-1:0]   sum;
   logic           accept_ok;
   logic           accept;
   logic [NREQ-1:0] ready_vec;

   for (genvar i = 0; i < NREQ; i++) begin : g_unpack
      assign a_arr[i] = bus.req_a[i*W +: W];
      assign b_arr[i] = bus.req_b[i*W +: W];
   end

   // Round-robin scan starting at rr_ptr, wrapping modulo NREQ
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      scan   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan = int'(rr_ptr) + k;
         if (scan >= NREQ) scan = scan - NREQ;
         idx = IDW'(scan);
         if (!found && bus.req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

`ifdef SEQ_ADD_ARBITER_SATURATE_EN
   logic [W:0] sum_full;
   assign sum_full = {1'b0, a_arr[winner]} + {1'b0, b_arr[winner]};
   assign sum      = sum_full[W] ? {W{1'b1}} : sum_full[W-1:0];
`else
   assign sum = a_arr[winner] + b_arr[winner];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_id_q    <= '0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_ptr_nxt;
         rsp_valid_q <= rsp_valid_nxt;
         rsp_data_q  <= rsp_data_nxt;
         rsp_id_q    <= rsp_id_nxt;
      end
   end

   // Next state: an accept while HOLD completes the old result and loads the new one
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      rsp_valid_nxt = rsp_valid_q;
      rsp_data_nxt  = rsp_data_q;
      rsp_id_nxt    = rsp_id_q;
      ready_vec     = '0;

      accept_ok = !rst && ((state == IDLE) || bus.rsp_ready);
      accept    = accept_ok && found;

      if (accept) begin
         ready_vec[winner] = 1'b1;
         state_nxt         = HOLD;
         rsp_valid_nxt     = 1'b1;
         rsp_data_nxt      = sum;
         rsp_id_nxt        = winner;
         rr_ptr_nxt        = (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
      end else if (state == HOLD && bus.rsp_ready) begin
         state_nxt     = IDLE;
         rsp_valid_nxt = 1'b0;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.busy      = rsp_valid_q;
endmodule

// File: tb/tb_seq_add_arbiter.sv
// Scoreboard bench for seq_add_arbiter: stimulus pushes expected results,
// a negedge monitor pops and compares on each response handshake.
module tb_seq_add_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 8;

`ifdef SEQ_ADD_ARBITER_SATURATE_EN
   localparam logic [7:0] WRAP_EXP = 8'hFF;
`else
   localparam logic [7:0] WRAP_EXP = 8'h10;
`endif

   typedef struct {
      int unsigned id;
      int unsigned data;
   } exp_t;

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   exp_t exp_q[$];

   seq_add_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

   seq_add_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[i*8 +: 8] = a;
      bus.req_b[i*8 +: 8] = b;
   endtask

   // Drive one cycle; check req_ready and rsp_valid mid-cycle; queue expected result on grant
   task automatic issue(input string nm, input logic [3:0] v, input logic rr,
                        input logic [3:0] er, input logic erv,
                        input int unsigned eid = 0, input int unsigned edat = 0);
      exp_t e;
      bus.req_valid = v;
      bus.rsp_ready = rr;
      @(negedge clk);
      chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'(er));
      chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(erv));
      if (er != 4'b0000) begin
         e.id   = eid;
         e.data = edat;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every completed response against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL mon_unexpected: got id %0d data 0x%0h, none expected",
                     bus.rsp_id, bus.rsp_data);
         end else begin
            e = exp_q.pop_front();
            chk("mon_id", 32'(bus.rsp_id), e.id);
            chk("mon_data", 32'(bus.rsp_data), e.data);
            chk("mon_busy", 32'(bus.busy), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t drop;
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.req_valid = 4'hF;
      bus.rsp_ready = 1'b1;
      bus.req_a = '0;
      bus.req_b = '0;
      set_ops(0, 8'h01, 8'h02);
      set_ops(1, 8'h10, 8'h20);
      set_ops(2, 8'h12, 8'h34);
      set_ops(3, 8'h7F, 8'h80);

      // Reset with every requester asserting valid
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_rsp_data", 32'(bus.rsp_data), 32'h00);
         chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      end
      rst = 1'b0;

      // Round-robin: grants 0,1,2,3,0,1 back to back
      issue("rr0", 4'hF, 1'b1, 4'b0001, 1'b0, 0, 8'h03);
      issue("rr1", 4'hF, 1'b1, 4'b0010, 1'b1, 1, 8'h30);
      issue("rr2", 4'hF, 1'b1, 4'b0100, 1'b1, 2, 8'h46);
      issue("rr3", 4'hF, 1'b1, 4'b1000, 1'b1, 3, 8'hFF);
      issue("rr4", 4'hF, 1'b1, 4'b0001, 1'b1, 0, 8'h03);
      issue("rr5", 4'hF, 1'b1, 4'b0010, 1'b1, 1, 8'h30);
      issue("rr_drain", 4'h0, 1'b1, 4'b0000, 1'b1);
      issue("rr_idle", 4'h0, 1'b1, 4'b0000, 1'b0);

      // Single request from requester 2
      issue("single", 4'b0100, 1'b1, 4'b0100, 1'b0, 2, 8'h46);
      issue("single_rsp", 4'h0, 1'b1, 4'b0000, 1'b1);
      issue("single_idle", 4'h0, 1'b1, 4'b0000, 1'b0);

      // Backpressure: requester 1 held three cycles, then requester 3 wins on release
      set_ops(1, 8'h05, 8'h06);
      issue("bp_acc", 4'b0010, 1'b1, 4'b0010, 1'b0, 1, 8'h0B);
      for (int i = 0; i < 3; i++) begin
         issue("bp_hold", 4'b1010, 1'b0, 4'b0000, 1'b1);
         chk("bp_hold_data", 32'(bus.rsp_data), 32'h0B);
         chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      end
      issue("bp_release", 4'b1010, 1'b1, 4'b1000, 1'b1, 3, 8'hFF);

      // Wrap versus saturate on requester 0
      set_ops(0, 8'hF0, 8'h20);
      issue("wrap", 4'b0001, 1'b1, 4'b0001, 1'b1, 0, WRAP_EXP);

      // Reset while a result is held unconsumed
      issue("pre_hold", 4'b0010, 1'b1, 4'b0010, 1'b1, 1, 8'h0B);
      issue("hold", 4'h0, 1'b0, 4'b0000, 1'b1);
      rst = 1'b1;
      bus.req_valid = 4'b0101;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) drop = exp_q.pop_front();
      rst = 1'b0;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_rsp_data", 32'(bus.rsp_data), 32'h00);
      chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
      issue("post_rst", 4'b0101, 1'b1, 4'b0001, 1'b0, 0, WRAP_EXP);
      issue("post_rsp", 4'h0, 1'b1, 4'b0000, 1'b1);
      issue("end_idle", 4'h0, 1'b1, 4'b0000, 1'b0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
